// File: rtl/mem_access_unit_if.sv
// Bundle of CPU-side request signals and data-memory strobes for mem_access_unit.
// The slave modport is the unit itself; master is whatever drives it (CPU + memory).
interface mem_access_unit_if;
    logic       req_read;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       stall;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       wr_done;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_busy;
    logic       timeout_err;

    modport slave (
        input  req_read, req_write, req_addr, req_wdata, mem_rdata, mem_busy,
        output stall, rdata, rdata_valid, wr_done, mem_read, mem_write,
        output mem_addr, mem_wdata, timeout_err
    );

    modport master (
        output req_read, req_write, req_addr, req_wdata, mem_rdata, mem_busy,
        input  stall, rdata, rdata_valid, wr_done, mem_read, mem_write,
        input  mem_addr, mem_wdata, timeout_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Serialises CPU loads/stores onto a busy-handshaked data memory, stalling the core meanwhile.
// Optional abort of hung accesses is compiled in with `define MAU_TIMEOUT_EN.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e     state_q, state_d;
    logic       opRead_q, opRead_d;
    logic       opWrite_q, opWrite_d;
    logic [7:0] memAddr_q, memAddr_d;
    logic [7:0] memWdata_q, memWdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       anyReq;
    logic       active;
    logic       timeoutHit;

    assign anyReq = bus.req_read | bus.req_write;
    assign active = (state_q == REQ) || (state_q == WAIT);

`ifdef MAU_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       timeoutErr_q, timeoutErr_d;

    // Counter is held at zero in IDLE so it starts fresh on every REQ entry
    always_comb begin
        cnt_d        = cnt_q;
        timeoutErr_d = timeoutErr_q | timeoutHit;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (active) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    assign timeoutHit      = active && (cnt_q == TimeoutLast);
    assign bus.timeout_err = timeoutErr_q;
`else
    logic unusedTimeoutParam;

    assign unusedTimeoutParam = (TIMEOUT_CYCLES != 0);
    assign timeoutHit         = 1'b0;
    assign bus.timeout_err    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        opRead_d   = opRead_q;
        opWrite_d  = opWrite_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                // A simultaneous load/store is treated as a load only
                if (anyReq) begin
                    state_d    = REQ;
                    opRead_d   = bus.req_read;
                    opWrite_d  = bus.req_write & ~bus.req_read;
                    memAddr_d  = bus.req_addr;
                    memWdata_d = bus.req_wdata;
                end
            end
            REQ: begin
                if (bus.mem_busy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!bus.mem_busy) begin
                    state_d = DONE;
                    if (opRead_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // An expired access completes normally but with a poisoned load value
        if (timeoutHit) begin
            state_d = DONE;
            if (opRead_q) begin
                rdata_d = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            opRead_q   <= 1'b0;
            opWrite_q  <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            opRead_q   <= opRead_d;
            opWrite_q  <= opWrite_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // Strobes and pulses decode from state so reset kills them without waiting for a clock
    assign bus.mem_read    = active & opRead_q;
    assign bus.mem_write   = active & opWrite_q;
    assign bus.mem_addr    = memAddr_q;
    assign bus.mem_wdata   = memWdata_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = (state_q == DONE) & opRead_q;
    assign bus.wr_done     = (state_q == DONE) & opWrite_q;
    assign bus.stall       = active || ((state_q == IDLE) && anyReq);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a busy-handshake memory model and a completion scoreboard.
// Define MAU_TIMEOUT_EN for both files to also exercise the hung-access abort.
module tb_mem_access_unit;

    localparam int TimeoutCycles = 8;

    typedef struct {
        logic       isRead;
        logic [7:0] data;
    } sbEntry_t;

    logic clk;
    logic rst;

    mem_access_unit_if bus ();

    mem_access_unit #(
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    sbEntry_t   sbQ[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         doneCount = 0;
    int         doneCyc = 0;
    int         entryCyc = 0;
    int         busyLen = 1;
    int         modelCnt = 0;
    logic       modelBusy;
    logic       served;
    logic       idleBusy;
    logic [7:0] modelRdata;
    bit   [7:0] memData[256];
    bit         memValid[256];
    logic [7:0] refData[256];
    bit         refValid[256];
    logic       expRead;
    logic       expWrite;
    logic [7:0] expAddr;
    logic [7:0] expWdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] initVal(input logic [7:0] a);
        if (a == 8'h00) return 8'h11;
        if (a == 8'h04) return 8'hC3;
        if (a == 8'h10) return 8'h5A;
        return a ^ 8'h3C;
    endfunction

    function automatic logic [7:0] memRead(input logic [7:0] a);
        return memValid[a] ? memData[a] : initVal(a);
    endfunction

    function automatic logic [7:0] refRead(input logic [7:0] a);
        return refValid[a] ? refData[a] : initVal(a);
    endfunction

    assign bus.mem_busy  = modelBusy | idleBusy;
    assign bus.mem_rdata = modelRdata;

    // Memory answers a strobe one edge later by holding busy for busyLen cycles
    always @(posedge clk) begin
        if (rst) begin
            modelBusy  <= 1'b0;
            modelCnt   <= 0;
            served     <= 1'b0;
            modelRdata <= 8'h00;
        end else if (modelCnt != 0) begin
            modelCnt <= modelCnt - 1;
            if (modelCnt == 1) begin
                modelBusy <= 1'b0;
                if (bus.mem_read) modelRdata <= memRead(bus.mem_addr);
                if (bus.mem_write) begin
                    memData[bus.mem_addr]  <= bus.mem_wdata;
                    memValid[bus.mem_addr] <= 1'b1;
                end
            end
        end else if ((bus.mem_read || bus.mem_write) && !served) begin
            modelBusy <= 1'b1;
            modelCnt  <= busyLen;
            served    <= 1'b1;
        end else if (!(bus.mem_read || bus.mem_write)) begin
            served <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Completion monitor: every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        sbEntry_t e;
        if (bus.rdata_valid || bus.wr_done) begin
            doneCount++;
            doneCyc = cyc;
            checkBit("sb_has_entry", sbQ.size() != 0, 1'b1);
            if (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                checkBit("rdata_valid_kind", bus.rdata_valid, e.isRead);
                checkBit("wr_done_kind", bus.wr_done, !e.isRead);
                if (e.isRead) checkOutput("rdata", bus.rdata, e.data);
            end
            checkBit("stall_in_done", bus.stall, 1'b0);
            checkBit("read_strobe_in_done", bus.mem_read, 1'b0);
            checkBit("write_strobe_in_done", bus.mem_write, 1'b0);
        end
        checkBit("strobe_exclusive", bus.mem_read & bus.mem_write, 1'b0);
    end

    task automatic startRequest(input logic rd, input logic wr, input logic [7:0] addr,
                                input logic [7:0] wdata, input int busyCycles);
        sbEntry_t e;
        busyLen       = busyCycles;
        bus.req_read  = rd;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        expRead       = rd;
        expWrite      = wr & ~rd;
        expAddr       = addr;
        expWdata      = wdata;
        e.isRead      = expRead;
        e.data        = 8'h00;
        if (expRead) begin
            e.data = refRead(addr);
        end else begin
            refData[addr]  = wdata;
            refValid[addr] = 1'b1;
        end
        sbQ.push_back(e);
        @(negedge clk);
        checkBit("stall_idle_req", bus.stall, 1'b1);
        @(posedge clk);
        #1;
        entryCyc      = cyc;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wdata;
    endtask

    task automatic waitDone(input int expLatency);
        int startDone = doneCount;
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (doneCount != startDone) begin
                seen = 1'b1;
            end else begin
                checkBit("mem_read", bus.mem_read, expRead);
                checkBit("mem_write", bus.mem_write, expWrite);
                checkOutput("mem_addr", bus.mem_addr, expAddr);
                if (expWrite) checkOutput("mem_wdata", bus.mem_wdata, expWdata);
                checkBit("stall_busy", bus.stall, 1'b1);
            end
        end
        checkBit("done_seen", seen, 1'b1);
        if (seen) checkOutput("latency", 8'(doneCyc - entryCyc), 8'(expLatency));
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr,
                                 input logic [7:0] wdata, input int busyCycles);
        startRequest(rd, wr, addr, wdata, busyCycles);
        waitDone(busyCycles + 2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int mark;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;
        idleBusy      = 1'b0;
        rst           = 1'b0;
        #1 rst = 1'b1;
        #2;
        $display("[TB] reset values");
        checkBit("rst_stall", bus.stall, 1'b0);
        checkBit("rst_mem_read", bus.mem_read, 1'b0);
        checkBit("rst_mem_write", bus.mem_write, 1'b0);
        checkOutput("rst_mem_addr", bus.mem_addr, 8'h00);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 8'h00);
        checkOutput("rst_rdata", bus.rdata, 8'h00);
        checkBit("rst_rdata_valid", bus.rdata_valid, 1'b0);
        checkBit("rst_wr_done", bus.wr_done, 1'b0);
        checkBit("rst_timeout_err", bus.timeout_err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] read preloaded 0x00, busy 3 cycles, first edge after reset");
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 3);

        $display("[TB] write 0x11 to 0x04 then read it back, back to back");
        applyStimulus(1'b0, 1'b1, 8'h04, 8'h11, 2);
        applyStimulus(1'b1, 1'b0, 8'h04, 8'h00, 1);

        $display("[TB] simultaneous read and write at 0x10");
        applyStimulus(1'b1, 1'b1, 8'h10, 8'hEE, 2);
        checkOutput("mem10_unchanged", memRead(8'h10), 8'h5A);

        $display("[TB] store leaves rdata untouched");
        applyStimulus(1'b0, 1'b1, 8'h20, 8'h77, 4);
        checkOutput("rdata_hold", bus.rdata, 8'h5A);
        checkOutput("mem20_written", memRead(8'h20), 8'h77);

        $display("[TB] busy in idle is ignored");
        mark     = doneCount;
        idleBusy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkBit("idle_busy_stall", bus.stall, 1'b0);
            checkBit("idle_busy_strobe", bus.mem_read | bus.mem_write, 1'b0);
        end
        @(posedge clk);
        #1 idleBusy = 1'b0;
        checkOutput("idle_busy_no_done", 8'(doneCount - mark), 8'd0);
        applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, 2);

        $display("[TB] reset during WAIT");
        startRequest(1'b1, 1'b0, 8'h00, 8'h00, 6);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkBit("pre_abort_read", bus.mem_read, 1'b1);
        mark = doneCount;
        #2 rst = 1'b1;
        #1;
        checkBit("abort_mem_read", bus.mem_read, 1'b0);
        checkBit("abort_mem_write", bus.mem_write, 1'b0);
        checkBit("abort_stall", bus.stall, 1'b0);
        checkOutput("abort_rdata", bus.rdata, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_no_done", 8'(doneCount - mark), 8'd0);
        checkOutput("abort_sb_pending", 8'(sbQ.size()), 8'd1);
        sbQ.delete();
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 8'h04, 8'h00, 2);

`ifdef MAU_TIMEOUT_EN
        begin
            sbEntry_t e;
            $display("[TB] stuck busy aborts after timeout");
            startRequest(1'b1, 1'b0, 8'h30, 8'h00, 200);
            e      = sbQ.pop_back();
            e.data = 8'hFF;
            sbQ.push_back(e);
            waitDone(TimeoutCycles);
            checkBit("timeout_err_set", bus.timeout_err, 1'b1);
            repeat (4) @(negedge clk);
            checkBit("timeout_err_sticky", bus.timeout_err, 1'b1);
            checkOutput("timeout_rdata", bus.rdata, 8'hFF);
            #2 rst = 1'b1;
            #1;
            checkBit("timeout_err_cleared", bus.timeout_err, 1'b0);
            @(posedge clk);
            #1 rst = 1'b0;
        end
`else
        checkBit("timeout_err_tied", bus.timeout_err, 1'b0);
`endif

        checkOutput("sb_drained", 8'(sbQ.size()), 8'd0);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
